// File: rtl/SpiGlobalsPkg.sv
// Shared SPI definitions: slave count and the slave controller state encoding.
package SpiGlobalsPkg;
    localparam int NO_OF_SLAVES = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one async input, with rise/fall strobes of the synchronized level.
// Latency: level 2 pclk, strobes asserted the cycle the synchronized level changes.
// Backpressure: none; free-running on every clock.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave oversampled on pclk: shifts MSB-first words in/out, one-deep tx buffer, rx holding register.
// Latency: rx_valid rises 3 pclk after the final sampling sclk edge.
// Backpressure: rx word dropped with rx_overrun if unread; empty tx buffer sends zeros with tx_underrun.
module spi_slave_ctrl
    import SpiGlobalsPkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter logic CPOL       = 1'b0,
    parameter logic CPHA       = 1'b0,
    parameter int   SLAVE_ID   = 0
) (
    input  logic                    pclk,
    input  logic                    areset,
    input  logic                    sclk,
    input  logic [NO_OF_SLAVES-1:0] cs,
    input  logic                    mosi0,
    output logic                    miso0,
    input  logic [DATA_WIDTH-1:0]   tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [DATA_WIDTH-1:0]   rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    rx_overrun,
    output logic                    tx_underrun
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic sclk_q_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise_unused, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic cs_unused;

    spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
        .clk(pclk), .rst_n(areset), .d(sclk),
        .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(pclk), .rst_n(areset), .d(cs[SLAVE_ID]),
        .q(cs_s), .rise(cs_rise_unused), .fall(cs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(pclk), .rst_n(areset), .d(mosi0),
        .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign cs_unused = ^cs;

    spi_state_e            state_q, state_d;
    logic                  start;
    logic [1:0]            primed_q;
    logic                  armed_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift, tx_shift, tx_buf, ld_word, rx_word;
    logic                  tx_full, miso_q;
    logic                  active, sample_edge, shift_edge, sample, shift_en;
    logic                  word_done, load, capture;

    // A transfer may only start after cs has been seen high once the synchronizer holds real data,
    // so a reset released mid-transfer waits for a genuine cs fall.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_q  <= IDLE;
            primed_q <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            primed_q <= {primed_q[0], 1'b1};
            if (primed_q[1] && cs_s)
                armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE:   if (cs_fall && armed_q) begin
                        state_d = ACTIVE;
                        start   = 1'b1;
                    end
            ACTIVE: if (cs_s) state_d = IDLE;
        endcase
    end

    assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
    assign shift_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;
    assign active      = (state_q == ACTIVE) && !cs_s;
    assign sample      = active && sample_edge;
    assign word_done   = sample && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign load        = start || word_done;
    assign ld_word     = tx_full ? tx_buf : '0;
    assign rx_word     = {rx_shift[DATA_WIDTH-2:0], mosi_s};
    assign capture     = tx_valid && !tx_full;
    // With CPHA=0 the MSB is already presented at load, so the trailing edge after the last sample is skipped.
    assign shift_en    = active && shift_edge && (CPHA || (bit_cnt != '0));

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (!active) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else if (sample) begin
            bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
            rx_shift <= rx_word;
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= load && !tx_full;
            if (capture) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end else if (load) begin
                tx_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            tx_shift <= '0;
            miso_q   <= 1'b0;
        end else if (load) begin
            if (CPHA) begin
                tx_shift <= ld_word;
            end else begin
                tx_shift <= {ld_word[DATA_WIDTH-2:0], 1'b0};
                miso_q   <= ld_word[DATA_WIDTH-1];
            end
        end else if (shift_en) begin
            miso_q   <= tx_shift[DATA_WIDTH-1];
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end else if (state_q == IDLE) begin
            tx_shift <= '0;
            miso_q   <= 1'b0;
        end
    end

    assign tx_ready = !tx_full;
    assign miso0    = miso_q && (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench: mode-0 slave on cs[0] (dut a) and mode-3 slave on cs[2] (dut b).
module tb_spi_slave_ctrl;
    import SpiGlobalsPkg::*;

    logic pclk = 1'b0;
    logic areset;
    always #5 pclk = ~pclk;

    logic                    sclk_a, mosi_a, miso_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a, rx_overrun_a, tx_underrun_a;
    logic [NO_OF_SLAVES-1:0] cs_a;
    logic [7:0]              tx_data_a, rx_data_a;
    logic                    sclk_b, mosi_b, miso_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b, rx_overrun_b, tx_underrun_b;
    logic [NO_OF_SLAVES-1:0] cs_b;
    logic [7:0]              tx_data_b, rx_data_b;

    spi_slave_ctrl #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .SLAVE_ID(0)) u_dut_a (
        .pclk(pclk), .areset(areset), .sclk(sclk_a), .cs(cs_a), .mosi0(mosi_a), .miso0(miso_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_overrun(rx_overrun_a), .tx_underrun(tx_underrun_a)
    );
    spi_slave_ctrl #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .SLAVE_ID(2)) u_dut_b (
        .pclk(pclk), .areset(areset), .sclk(sclk_b), .cs(cs_b), .mosi0(mosi_b), .miso0(miso_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .rx_overrun(rx_overrun_b), .tx_underrun(tx_underrun_b)
    );

    int checks = 0;
    int errors = 0;

    // Event monitors: pulse counts and accepted rx words.
    int ovr_a = 0, und_a = 0, acc_a = 0, und_b = 0, acc_b = 0;
    logic [7:0] acc_last_a = 8'h00, acc_last_b = 8'h00, acc_prev_b = 8'h00;
    always @(negedge pclk) begin
        if (rx_overrun_a) ovr_a++;
        if (tx_underrun_a) und_a++;
        if (tx_underrun_b) und_b++;
        if (rx_valid_a && rx_ready_a) begin acc_a++; acc_last_a = rx_data_a; end
        if (rx_valid_b && rx_ready_b) begin acc_b++; acc_prev_b = acc_last_b; acc_last_b = rx_data_b; end
    end

    task automatic hw();
        repeat (5) @(negedge pclk);
    endtask

    task automatic push_a(input logic [7:0] d);
        int n = 0;
        while (!tx_ready_a && n < 20) begin @(negedge pclk); n++; end
        checks++;
        if (!tx_ready_a) begin errors++; $display("FAIL push_a tx_ready stuck got %b want 1", tx_ready_a); end
        tx_data_a = d; tx_valid_a = 1'b1;
        @(negedge pclk);
        tx_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        int n = 0;
        while (!tx_ready_b && n < 20) begin @(negedge pclk); n++; end
        checks++;
        if (!tx_ready_b) begin errors++; $display("FAIL push_b tx_ready stuck got %b want 1", tx_ready_b); end
        tx_data_b = d; tx_valid_b = 1'b1;
        @(negedge pclk);
        tx_valid_b = 1'b0;
    endtask

    // Mode 0 master: mosi set after sclk falls, both sides sample on rise.
    task automatic xfer_a(input logic [7:0] w, input int nbits, output logic [7:0] mi, output int lat);
        mi = 8'h00; lat = 0;
        for (int i = 0; i < nbits; i++) begin
            mosi_a = w[7-i];
            hw();
            mi = {mi[6:0], miso_a};
            sclk_a = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                @(negedge pclk);
                if (i == nbits - 1 && lat == 0 && rx_valid_a) lat = k;
            end
            sclk_a = 1'b0;
        end
    endtask

    // Mode 3 master: falling edge shifts, rising edge samples, sclk idles high.
    task automatic xfer_b(input logic [7:0] w, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sclk_b = 1'b0; mosi_b = w[7-i];
            hw();
            mi = {mi[6:0], miso_b};
            sclk_b = 1'b1;
            hw();
        end
    endtask

    task automatic test_reset();
        checks++; if (miso_a !== 1'b0) begin errors++; $display("FAIL rst_miso got %b want 0", miso_a); end
        checks++; if (rx_data_a !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h want 00", rx_data_a); end
        checks++; if (rx_valid_a !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b want 0", rx_valid_a); end
        checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b want 1", tx_ready_a); end
        checks++; if (rx_overrun_a !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", rx_overrun_a); end
        checks++; if (tx_underrun_a !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b want 0", tx_underrun_a); end
        checks++; if (tx_ready_b !== 1'b1 || miso_b !== 1'b0) begin errors++; $display("FAIL rst_b got rdy %b miso %b want 1 0", tx_ready_b, miso_b); end
        areset = 1'b1;
        repeat (5) @(negedge pclk);
    endtask

    task automatic test_mode0_basic();
        logic [7:0] mi; int lat;
        push_a(8'hA5);
        checks++; if (tx_ready_a !== 1'b0) begin errors++; $display("FAIL m0_buf_full got %b want 0", tx_ready_a); end
        cs_a[0] = 1'b0; repeat (10) @(negedge pclk);
        checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL m0_buf_freed got %b want 1", tx_ready_a); end
        xfer_a(8'h3C, 8, mi, lat);
        checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL m0_miso got %h want a5", mi); end
        checks++; if (lat < 1 || lat > 4) begin errors++; $display("FAIL m0_latency got %0d want 1..4", lat); end
        checks++; if (rx_data_a !== 8'h3C) begin errors++; $display("FAIL m0_rx_data got %h want 3c", rx_data_a); end
        cs_a[0] = 1'b1; repeat (10) @(negedge pclk);
        checks++; if (miso_a !== 1'b0) begin errors++; $display("FAIL m0_idle_miso got %b want 0", miso_a); end
    endtask

    task automatic test_underrun();
        logic [7:0] mi; int lat; int u0;
        u0 = und_a;
        cs_a[0] = 1'b0; repeat (10) @(negedge pclk);
        checks++; if (und_a - u0 != 1) begin errors++; $display("FAIL und_pulse got %0d want 1", und_a - u0); end
        xfer_a(8'h55, 8, mi, lat);
        checks++; if (mi !== 8'h00) begin errors++; $display("FAIL und_miso got %h want 00", mi); end
        checks++; if (rx_data_a !== 8'h55) begin errors++; $display("FAIL und_rx_data got %h want 55", rx_data_a); end
        cs_a[0] = 1'b1; repeat (10) @(negedge pclk);
    endtask

    task automatic test_overrun();
        logic [7:0] mi; int lat; int o0;
        rx_ready_a = 1'b0; o0 = ovr_a;
        cs_a[0] = 1'b0; repeat (10) @(negedge pclk);
        xfer_a(8'h11, 8, mi, lat);
        xfer_a(8'h22, 8, mi, lat);
        cs_a[0] = 1'b1; repeat (10) @(negedge pclk);
        checks++; if (rx_data_a !== 8'h11) begin errors++; $display("FAIL ovr_rx_data got %h want 11", rx_data_a); end
        checks++; if (rx_valid_a !== 1'b1) begin errors++; $display("FAIL ovr_rx_valid got %b want 1", rx_valid_a); end
        checks++; if (ovr_a - o0 != 1) begin errors++; $display("FAIL ovr_pulses got %0d want 1", ovr_a - o0); end
        rx_ready_a = 1'b1;
        @(negedge pclk);
        checks++; if (rx_valid_a !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear got %b want 0", rx_valid_a); end
        repeat (3) @(negedge pclk);
    endtask

    task automatic test_abort();
        logic [7:0] mi; int lat; int a0;
        a0 = acc_a;
        cs_a[0] = 1'b0; repeat (10) @(negedge pclk);
        push_a(8'h96);
        xfer_a(8'hAB, 5, mi, lat);
        cs_a[0] = 1'b1; repeat (10) @(negedge pclk);
        checks++; if (acc_a != a0 || rx_valid_a !== 1'b0) begin errors++; $display("FAIL abort_no_word got acc %0d valid %b want 0 0", acc_a - a0, rx_valid_a); end
        checks++; if (tx_ready_a !== 1'b0) begin errors++; $display("FAIL abort_buf_kept got %b want 0", tx_ready_a); end
        cs_a[0] = 1'b0; repeat (10) @(negedge pclk);
        checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL abort_buf_loaded got %b want 1", tx_ready_a); end
        xfer_a(8'hF0, 8, mi, lat);
        checks++; if (mi !== 8'h96) begin errors++; $display("FAIL abort_miso got %h want 96", mi); end
        cs_a[0] = 1'b1; repeat (10) @(negedge pclk);
        checks++; if (acc_a - a0 != 1 || acc_last_a !== 8'hF0) begin errors++; $display("FAIL abort_word got n %0d data %h want 1 f0", acc_a - a0, acc_last_a); end
    endtask

    task automatic test_back_to_back_mode3();
        logic [7:0] mi1, mi2; int u0, a0;
        u0 = und_b; a0 = acc_b;
        push_b(8'hC3);
        cs_b[2] = 1'b0; repeat (10) @(negedge pclk);
        push_b(8'h5A);
        xfer_b(8'h81, mi1);
        push_b(8'h0F);
        xfer_b(8'h7E, mi2);
        cs_b[2] = 1'b1; repeat (10) @(negedge pclk);
        checks++; if (mi1 !== 8'hC3) begin errors++; $display("FAIL b2b_miso1 got %h want c3", mi1); end
        checks++; if (mi2 !== 8'h5A) begin errors++; $display("FAIL b2b_miso2 got %h want 5a", mi2); end
        checks++; if (acc_b - a0 != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", acc_b - a0); end
        checks++; if (acc_prev_b !== 8'h81 || acc_last_b !== 8'h7E) begin errors++; $display("FAIL b2b_words got %h %h want 81 7e", acc_prev_b, acc_last_b); end
        checks++; if (und_b != u0) begin errors++; $display("FAIL b2b_underrun got %0d want 0", und_b - u0); end
        checks++; if (miso_b !== 1'b0) begin errors++; $display("FAIL b2b_idle_miso got %b want 0", miso_b); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] mi; int lat; int a0;
        cs_a[0] = 1'b0; repeat (10) @(negedge pclk);
        push_a(8'h3C);
        xfer_a(8'hFF, 4, mi, lat);
        areset = 1'b0;
        #1;
        checks++; if (miso_a !== 1'b0) begin errors++; $display("FAIL rmid_miso got %b want 0", miso_a); end
        checks++; if (rx_data_a !== 8'h00) begin errors++; $display("FAIL rmid_rx_data got %h want 00", rx_data_a); end
        checks++; if (rx_valid_a !== 1'b0) begin errors++; $display("FAIL rmid_rx_valid got %b want 0", rx_valid_a); end
        checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL rmid_tx_ready got %b want 1", tx_ready_a); end
        checks++; if (rx_overrun_a !== 1'b0 || tx_underrun_a !== 1'b0) begin errors++; $display("FAIL rmid_pulses got %b %b want 0 0", rx_overrun_a, tx_underrun_a); end
        repeat (3) @(negedge pclk);
        areset = 1'b1;
        a0 = acc_a;
        xfer_a(8'hFF, 4, mi, lat);
        xfer_a(8'h99, 8, mi, lat);
        checks++; if (mi !== 8'h00) begin errors++; $display("FAIL rmid_no_shift got %h want 00", mi); end
        checks++; if (acc_a != a0 || rx_valid_a !== 1'b0) begin errors++; $display("FAIL rmid_no_word got acc %0d valid %b want 0 0", acc_a - a0, rx_valid_a); end
        cs_a[0] = 1'b1; repeat (10) @(negedge pclk);
        cs_a[0] = 1'b0; repeat (10) @(negedge pclk);
        xfer_a(8'h42, 8, mi, lat);
        cs_a[0] = 1'b1; repeat (10) @(negedge pclk);
        checks++; if (acc_a - a0 != 1 || acc_last_a !== 8'h42) begin errors++; $display("FAIL rmid_fresh got n %0d data %h want 1 42", acc_a - a0, acc_last_a); end
    endtask

    initial begin
        areset = 1'b0;
        sclk_a = 1'b0; mosi_a = 1'b0; cs_a = '1; tx_data_a = 8'h00; tx_valid_a = 1'b0; rx_ready_a = 1'b1;
        sclk_b = 1'b1; mosi_b = 1'b0; cs_b = '1; tx_data_b = 8'h00; tx_valid_b = 1'b0; rx_ready_b = 1'b1;
        repeat (3) @(negedge pclk);
        test_reset();
        test_mode0_basic();
        test_underrun();
        test_overrun();
        test_abort();
        test_back_to_back_mode3();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per SPI word.
REQ-002 Parameter CPOL, default 0: sclk idle level.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter SLAVE_ID, default 0: index of the cs bit that selects this slave, range 0..NO_OF_SLAVES-1.
REQ-005 pclk  in  1  system clock; the block's single clock.
REQ-006 areset  in  1  asynchronous, active-low reset.
REQ-007 sclk  in  1  SPI serial clock from master; asynchronous to pclk.
REQ-008 cs  in  NO_OF_SLAVES  active-low chip selects.
REQ-009 mosi0  in  1  master-out slave-in data.
REQ-010 miso0  out  1  master-in slave-out data.
REQ-011 tx_data  in  DATA_WIDTH  next word to transmit.
REQ-012 tx_valid  in  1  tx_data offered.
REQ-013 tx_ready  out  1  transmit holding buffer empty.
REQ-014 rx_data  out  DATA_WIDTH  last received word.
REQ-015 rx_valid  out  1  rx_data holds an unread word.
REQ-016 rx_ready  in  1  consumer accepts rx_data.
REQ-017 rx_overrun  out  1  one-cycle pulse: completed word dropped.
REQ-018 tx_underrun  out  1  one-cycle pulse: word load found an empty buffer.

Function
REQ-019 sclk, cs[SLAVE_ID] and mosi0 SHALL each pass through a 2-flop synchronizer on pclk; edges SHALL be detected from the synchronized sclk; supported sclk frequency is at most pclk/8.
REQ-020 Sample edge SHALL be rising when CPOL==CPHA and falling otherwise; shift edge is the opposite edge.
REQ-021 FSM states: IDLE (cs[SLAVE_ID] high), ACTIVE (selected, shifting); IDLE->ACTIVE on synchronized cs fall; ACTIVE->IDLE on synchronized cs rise.
REQ-022 On IDLE->ACTIVE the shift register SHALL load the tx buffer and free it (tx_ready=1 next cycle); if the buffer is empty it SHALL load all-zeros and pulse tx_underrun.
REQ-023 Bits are MSB first on both mosi0 and miso0; with CPHA=0 the MSB SHALL be on miso0 by the cycle after the load, and with CPHA=1 it SHALL be presented on the first shift edge.
REQ-024 Each sample edge SHALL shift mosi0 into the rx shift register and increment a bit counter 0..DATA_WIDTH-1.
REQ-025 On the DATA_WIDTH-th sample the counter SHALL wrap to 0, the word SHALL be offered to rx_data, and the tx shift register SHALL reload from the buffer per REQ-022 for back-to-back words without cs toggling.
REQ-026 rx handshake: if rx_valid==0 or rx_ready==1 that cycle, rx_data updates and rx_valid=1 on the next cycle; if rx_valid==1 and rx_ready==0, the new word is dropped, rx_data is unchanged and rx_overrun pulses.
REQ-027 rx_valid SHALL clear the cycle after rx_valid&&rx_ready unless a new word is written in the same cycle.
REQ-028 Completed-word latency: rx_valid SHALL rise no later than 4 pclk cycles after the final sampling sclk edge.
REQ-029 tx handshake: tx_data is captured when tx_valid&&tx_ready; tx_ready=0 while the buffer is full; a capture and a load in the same cycle SHALL leave the buffer holding the new word.
REQ-030 cs rise mid-word SHALL discard the partial rx word, reset the bit counter, assert no rx_valid, and leave the tx buffer contents unchanged.
REQ-031 miso0 SHALL be 0 while in IDLE; the block contains no tristate drivers.

Reset
REQ-032 Asserting areset low SHALL immediately force: FSM=IDLE, counter=0, shift registers=0, synchronizers=reset values (sclk sync to CPOL, cs sync to 1, mosi sync to 0), miso0=0, rx_data=0, rx_valid=0, tx_ready=1, rx_overrun=0, tx_underrun=0.
REQ-033 Reset release mid-transfer SHALL require a fresh cs fall before any shifting.

Structure
REQ-034 NO_OF_SLAVES SHALL come from SpiGlobalsPkg; the FSM state enum SHALL be added to SpiGlobalsPkg.
REQ-035 A sub-module spi_sync_edge (2-flop synchronizer plus rise/fall strobes) SHALL be instantiated once for sclk, and the same synchronizer SHALL be reused for cs and mosi0.

Verification
REQ-036 CPOL=0/CPHA=0, tx=8'hA5 preloaded, master sends 8'h3C -> miso0 shifts 1,0,1,0,0,1,0,1, rx_data=8'h3C, rx_valid within 4 pclk.
REQ-037 CPOL=1/CPHA=1, two back-to-back words 8'h81, 8'h7E under one cs, tx buffer refilled between them -> two rx_valid pulses, no underrun.
REQ-038 Empty tx buffer at cs fall -> tx_underrun pulse, miso0 all zeros for the word.
REQ-039 rx_ready held 0, two words 8'h11, 8'h22 -> rx_data stays 8'h11, one rx_overrun pulse.
REQ-040 cs deasserted after 5 bits, then a full word 8'hF0 -> only 8'hF0 reported.
REQ-041 areset asserted mid-word -> all outputs at REQ-032 values within the same cycle, with no rx_valid after release.
